// File: rtl/melody_pkg.sv
// Shared definitions for the falling-note game: lane layout, song state encoding
// and a lane popcount helper.
package melody_pkg;

  localparam int LANES      = 4;
  localparam int LANE_LEFT  = 3;  // bit 3 is the renderer's leftmost column
  localparam int LANE_RIGHT = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [2:0] popcount4(input logic [LANES-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Per-lane 2-flop synchronizer for active-low buttons with a registered
// press (1-to-0) detector; a held button yields exactly one press pulse.
module key_sync
  import melody_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [LANES-1:0] key_n_i,
  output logic [LANES-1:0] press_o
);

  logic [LANES-1:0] meta_q;
  logic [LANES-1:0] sync_q;
  logic [LANES-1:0] prev_q;
  logic [LANES-1:0] press_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q  <= '1;
      sync_q  <= '1;
      prev_q  <= '1;
      press_q <= '0;
    end else begin
      meta_q  <= key_n_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      press_q <= prev_q & ~sync_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/note_judge.sv
// Hit/miss judge for the scrolling note chart: row pipeline, hit-window search,
// score and miss counters, and the song state machine.
module note_judge
  import melody_pkg::*;
#(
  parameter int DEPTH      = 10,
  parameter int WIN_LO     = 9,
  parameter int MISS_LIMIT = 20,
  parameter int SCORE_W    = 10
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               step_strobe_i,
  input  logic [LANES-1:0]   note_in_i,
  input  logic               chart_end_i,
  input  logic [LANES-1:0]   key_n_i,
  output logic               hit_o,
  output logic [LANES-1:0]   hit_lane_o,
  output logic               miss_o,
  output logic [7:0]         miss_count_o,
  output logic [SCORE_W-1:0] score_o,
  output logic               done_o,
  output logic               total_miss_o
);

  state_e               state_q;
  logic [LANES-1:0]     rows_q   [DEPTH+1];
  logic [LANES-1:0]     rows_clr [DEPTH+1];
  logic [LANES-1:0]     press;
  logic [LANES-1:0]     hit_vec;
  logic [LANES-1:0]     rows_any;
  logic                 active;
  logic                 shift;
  logic [2:0]           n_hits;
  logic [2:0]           n_miss;
  logic [SCORE_W:0]     score_sum;
  logic [SCORE_W-1:0]   score_d;
  logic [8:0]           miss_sum;
  logic [7:0]           miss_count_d;
  logic                 hit_q;
  logic [LANES-1:0]     hit_lane_q;
  logic                 miss_q;
  logic [7:0]           miss_count_q;
  logic [SCORE_W-1:0]   score_q;
  logic                 done_q;
  logic                 total_miss_q;

  key_sync u_key_sync (
    .clk_i   (clk_i),
    .rst_i   (reset_i),
    .key_n_i (key_n_i),
    .press_o (press)
  );

  assign active = (state_q == ST_PLAY) || (state_q == ST_DRAIN);
  assign shift  = active && step_strobe_i && !start_i;

  // Presses are judged on the pre-shift rows; the shift then moves the cleared rows.
  always_comb begin
    hit_vec  = '0;
    rows_any = '0;
    for (int r = 0; r <= DEPTH; r++) begin
      rows_clr[r] = rows_q[r];
      rows_any    = rows_any | rows_q[r];
    end
    if (active) begin
      for (int l = LANE_RIGHT; l <= LANE_LEFT; l++) begin
        for (int r = DEPTH; r >= WIN_LO; r--) begin
          if (press[l] && !hit_vec[l] && rows_q[r][l]) begin
            rows_clr[r][l] = 1'b0;
            hit_vec[l]     = 1'b1;
          end
        end
      end
    end
  end

  assign n_hits       = popcount4(hit_vec);
  assign n_miss       = shift ? popcount4(rows_clr[DEPTH]) : 3'd0;
  assign score_sum    = {1'b0, score_q} + (SCORE_W+1)'(n_hits);
  assign score_d      = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  assign miss_sum     = {1'b0, miss_count_q} + {6'b0, n_miss};
  assign miss_count_d = miss_sum[8] ? 8'hFF : miss_sum[7:0];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      for (int r = 0; r <= DEPTH; r++) rows_q[r] <= '0;
      hit_q        <= 1'b0;
      hit_lane_q   <= '0;
      miss_q       <= 1'b0;
      miss_count_q <= '0;
      score_q      <= '0;
      done_q       <= 1'b0;
      total_miss_q <= 1'b0;
    end else if (start_i) begin
      state_q      <= ST_PLAY;
      for (int r = 0; r <= DEPTH; r++) rows_q[r] <= '0;
      hit_q        <= 1'b0;
      hit_lane_q   <= '0;
      miss_q       <= 1'b0;
      miss_count_q <= '0;
      score_q      <= '0;
      done_q       <= 1'b0;
      total_miss_q <= 1'b0;
    end else begin
      hit_q        <= |hit_vec;
      if (|hit_vec) hit_lane_q <= hit_vec;
      miss_q       <= (n_miss != 3'd0);
      score_q      <= score_d;
      miss_count_q <= miss_count_d;
      if (miss_count_d >= 8'(MISS_LIMIT)) total_miss_q <= 1'b1;

      if (shift) begin
        rows_q[0] <= (state_q == ST_PLAY) ? note_in_i : '0;
        for (int r = 0; r < DEPTH; r++) rows_q[r+1] <= rows_clr[r];
      end else begin
        for (int r = 0; r <= DEPTH; r++) rows_q[r] <= rows_clr[r];
      end

      case (state_q)
        ST_PLAY: begin
          if (total_miss_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else if (chart_end_i) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (total_miss_q || (rows_any == '0)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hit_o        = hit_q;
  assign hit_lane_o   = hit_lane_q;
  assign miss_o       = miss_q;
  assign miss_count_o = miss_count_q;
  assign score_o      = score_q;
  assign done_o       = done_q;
  assign total_miss_o = total_miss_q;

endmodule
